dsp_stream_select: RTL and testbench

DSP_STREAM_SELECT -- requirements
Module: dsp_stream_select

---
 rtl/dsp_stream_select.sv | 198 +++++++++++++++++++
 tb/tb_dsp_stream_select.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_stream_select.sv
// Frame-aware N:1 AXI-Stream channel selector with AHB-Lite control registers.
// Channel switches and disables only take effect at frame boundaries.
module dsp_stream_select #(
    parameter  int DW = 16,
    parameter  int CH = 4,
    localparam int SW = $clog2(CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH*DW-1:0] tdata_s,
    input  logic [CH-1:0]    tvalid_s,
    input  logic [CH-1:0]    tlast_s,
    input  logic [CH-1:0]    tuser_s,
    output logic [CH-1:0]    tready_s,
    output logic [DW-1:0]    tdata_m,
    output logic             tvalid_m,
    output logic             tlast_m,
    output logic             tuser_m,
    input  logic             tready_m,
    input  logic [31:0]      haddr_s,
    input  logic [2:0]       hburst_s,
    input  logic [2:0]       hsize_s,
    input  logic [1:0]       htrans_s,
    input  logic [31:0]      hwdata_s,
    input  logic             hwrite_s,
    input  logic             hsel_s,
    output logic [31:0]      hrdata_s,
    output logic             hreadyout_s,
    output logic             hresp_s,
    output logic             interrupt
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS} state_t;

    state_t        state, state_nx;
    logic          en, drain, irqen, swdone;
    logic [SW-1:0] sel, act, act_nx;
    logic [31:0]   fcnt;
    logic          wr_q;
    logic [1:0]    addr_q;
    logic          ahb_valid, wr_ctrl, wr_fcnt, wr_irq, sel_ok;
    logic [31:0]   ctrl_rd, status_rd, rd_mux;
    logic [DW-1:0] act_data;
    logic          act_valid, act_last, act_user;
    logic          out_free, accept, set_done;
    logic          unused;

    assign hreadyout_s = 1'b1;
    assign hresp_s     = 1'b0;
    assign unused      = ^{hburst_s, hsize_s, htrans_s[0], haddr_s, hwdata_s};

    assign act_data  = tdata_s[act*DW +: DW];
    assign act_valid = tvalid_s[act];
    assign act_last  = tlast_s[act];
    assign act_user  = tuser_s[act];
    assign out_free  = !tvalid_m || tready_m;

    // ---------------- AHB-Lite slave ----------------
    assign ahb_valid = hsel_s && htrans_s[1];
    assign wr_ctrl   = wr_q && (addr_q == 2'd0);
    assign wr_fcnt   = wr_q && (addr_q == 2'd2);
    assign wr_irq    = wr_q && (addr_q == 2'd3);
    assign sel_ok    = 32'(hwdata_s[8 +: SW]) < 32'(CH);

    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[0]         = en;
        ctrl_rd[1]         = drain;
        ctrl_rd[2]         = irqen;
        ctrl_rd[8 +: SW]   = sel;
        status_rd          = '0;
        status_rd[0]       = (state == PASS);
        status_rd[1]       = (state == PASS) && ((sel != act) || !en);
        status_rd[8 +: SW] = act;
        case (haddr_s[3:2])
            2'd0:    rd_mux = ctrl_rd;
            2'd1:    rd_mux = status_rd;
            2'd2:    rd_mux = fcnt;
            default: rd_mux = {31'b0, swdone};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q     <= 1'b0;
            addr_q   <= 2'd0;
            hrdata_s <= '0;
        end else begin
            wr_q   <= ahb_valid && hwrite_s;
            addr_q <= haddr_s[3:2];
            if (ahb_valid && !hwrite_s)
                hrdata_s <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en     <= 1'b0;
            drain  <= 1'b0;
            irqen  <= 1'b0;
            sel    <= '0;
            fcnt   <= '0;
            swdone <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en    <= hwdata_s[0];
                drain <= hwdata_s[1];
                irqen <= hwdata_s[2];
                if (sel_ok)
                    sel <= hwdata_s[8 +: SW];
            end
            if (wr_fcnt)
                fcnt <= '0;
            else if (tvalid_m && tready_m && tlast_m)
                fcnt <= fcnt + 32'd1;
            // a switch completing in the same cycle as a W1C keeps SWDONE set
            if (set_done)
                swdone <= 1'b1;
            else if (wr_irq && hwdata_s[0])
                swdone <= 1'b0;
        end
    end

    assign interrupt = swdone & irqen;

    // ---------------- selection FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            act   <= '0;
        end else begin
            state <= state_nx;
            act   <= act_nx;
        end
    end

    always_comb begin
        state_nx = state;
        act_nx   = act;
        tready_s = {CH{drain}};
        accept   = 1'b0;
        set_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    act_nx   = sel;
                    state_nx = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (!en) begin
                    state_nx = IDLE;
                end else begin
                    // non-SOF beats are flushed; SOF waits for a free output slot
                    tready_s[act] = !act_user || out_free;
                    if (act_valid && act_user && out_free) begin
                        accept   = 1'b1;
                        set_done = 1'b1;
                        state_nx = PASS;
                    end
                end
            end
            PASS: begin
                tready_s[act] = out_free;
                if (act_valid && out_free) begin
                    accept = 1'b1;
                    if (act_last) begin
                        if (!en) begin
                            state_nx = IDLE;
                        end else if (sel != act) begin
                            act_nx   = sel;
                            state_nx = WAIT_SOF;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tdata_m  <= '0;
            tvalid_m <= 1'b0;
            tlast_m  <= 1'b0;
            tuser_m  <= 1'b0;
        end else if (accept) begin
            tdata_m  <= act_data;
            tvalid_m <= 1'b1;
            tlast_m  <= act_last;
            tuser_m  <= act_user;
        end else if (tready_m) begin
            tvalid_m <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_stream_select.sv
// Scoreboard bench for dsp_stream_select: source tasks push expected beats,
// a monitor thread pops and compares them at each output handshake.
module tb_dsp_stream_select;
    localparam int DW = 16;
    localparam int CH = 5;

    typedef struct packed {
        int            stamp;
        logic          u;
        logic          l;
        logic [DW-1:0] d;
    } exp_t;

    logic             clk, reset;
    logic [CH*DW-1:0] tdata_s;
    logic [CH-1:0]    tvalid_s, tlast_s, tuser_s, tready_s;
    logic [DW-1:0]    tdata_m;
    logic             tvalid_m, tlast_m, tuser_m, tready_m;
    logic [31:0]      haddr_s, hwdata_s, hrdata_s;
    logic [2:0]       hburst_s, hsize_s;
    logic [1:0]       htrans_s;
    logic             hwrite_s, hsel_s, hreadyout_s, hresp_s, interrupt;

    int          checks, errors, cyc, frames_seen;
    bit          rmode, rdy_fix, rnd_bit, lat_chk, arm_first, first_user, stall_prev;
    logic [DW+1:0] stall_val;
    exp_t        q[$];
    exp_t        e;
    logic [31:0] rd;

    assign tready_m = rmode ? rnd_bit : rdy_fix;

    dsp_stream_select #(.DW(DW), .CH(CH)) dut (
        .clk(clk), .reset(reset),
        .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tlast_s(tlast_s), .tuser_s(tuser_s),
        .tready_s(tready_s),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tlast_m(tlast_m), .tuser_m(tuser_m),
        .tready_m(tready_m),
        .haddr_s(haddr_s), .hburst_s(hburst_s), .hsize_s(hsize_s), .htrans_s(htrans_s),
        .hwdata_s(hwdata_s), .hwrite_s(hwrite_s), .hsel_s(hsel_s),
        .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
        .interrupt(interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = a; hwrite_s = 1'b1;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = a; hwrite_s = 1'b0;
        @(posedge clk); #1;
        d = hrdata_s;
        hsel_s = 1'b0; htrans_s = 2'b00;
    endtask

    task automatic send_beat(input int ch, input logic [DW-1:0] d, input logic u,
                             input logic l, input bit fwd);
        int n;
        exp_t x;
        tdata_s[ch*DW +: DW] = d;
        tuser_s[ch] = u; tlast_s[ch] = l; tvalid_s[ch] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tready_s[ch] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!tready_s[ch]) begin
            checks++; errors++;
            $display("FAIL send_timeout ch=%0d data=%h never accepted", ch, d);
            tvalid_s[ch] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (fwd) begin
            x.stamp = cyc; x.u = u; x.l = l; x.d = d;
            q.push_back(x);
        end
        tvalid_s[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || tvalid_m) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0 || tvalid_m) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d tvalid_m=%b required 0/0", q.size(), tvalid_m);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({tvalid_m, tlast_m, tuser_m, tdata_m} !== '0) begin
            errors++; $display("FAIL rst_out got %b%b%b %h required all 0", tvalid_m, tlast_m, tuser_m, tdata_m);
        end
        checks++;
        if ({tready_s, interrupt, hrdata_s} !== '0) begin
            errors++; $display("FAIL rst_misc tready_s=%b irq=%b hrdata=%h required 0", tready_s, interrupt, hrdata_s);
        end
        checks++;
        if ({hreadyout_s, hresp_s} !== 2'b10) begin
            errors++; $display("FAIL ahb_const got %b%b required 10", hreadyout_s, hresp_s);
        end
        reset = 1'b0;
        ahb_read(32'h4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got %h required 0", rd); end
    endtask

    task automatic test_basic();
        lat_chk = 1'b1;
        ahb_write(32'h0, 32'h5);
        send_beat(0, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        send_beat(0, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1024; i++)
            send_beat(0, 16'(i + 1), i == 0, i == 1023, 1'b1);
        wait_idle();
        lat_chk = 1'b0;
        ahb_read(32'h8, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL basic_fcnt got %0d required 1", rd); end
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_irq got %b required 1", interrupt); end
        ahb_read(32'h4, rd);
        checks++;
        if (rd !== 32'h001) begin errors++; $display("FAIL basic_status got %h required 001", rd); end
        ahb_write(32'hC, 32'h1);
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b required 0", interrupt); end
    endtask

    task automatic test_drain();
        tvalid_s[1] = 1'b1; tuser_s[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (tready_s[1] !== 1'b0) begin errors++; $display("FAIL drain0_ready got %b required 0", tready_s[1]); end
        @(posedge clk); #1;
        ahb_write(32'h0, 32'h7);
        @(negedge clk);
        checks++;
        if (tready_s[1] !== 1'b1) begin errors++; $display("FAIL drain1_ready got %b required 1", tready_s[1]); end
        @(posedge clk); #1;
        ahb_write(32'h0, 32'h5);
        tvalid_s[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_switch();
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_beat(0, 16'(16'h100 + i), i == 0, i == 29, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ahb_write(32'h0, 32'h205);
                ahb_read(32'h4, rd);
                checks++;
                if (rd !== 32'h003) begin errors++; $display("FAIL midframe_status got %h required 003", rd); end
            end
        join
        wait_idle();
        ahb_read(32'h4, rd);
        checks++;
        if (rd !== 32'h200) begin errors++; $display("FAIL switched_status got %h required 200", rd); end
        tvalid_s[0] = 1'b1; tuser_s[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (tready_s[0] !== 1'b0) begin errors++; $display("FAIL old_ch_ready got %b required 0", tready_s[0]); end
        @(posedge clk); #1;
        tvalid_s[0] = 1'b0;
        send_beat(2, 16'h2222, 1'b0, 1'b0, 1'b0);
        send_beat(2, 16'h2223, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            send_beat(2, 16'(16'h2300 + i), i == 0, i == 7, 1'b1);
        wait_idle();
        ahb_read(32'h4, rd);
        checks++;
        if (rd !== 32'h201) begin errors++; $display("FAIL ch2_status got %h required 201", rd); end
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL switch_irq got %b required 1", interrupt); end
    endtask

    task automatic test_stall();
        rmode = 1'b1;
        for (int i = 0; i < 1024; i++)
            send_beat(2, 16'(i + 1), i == 0, i == 1023, 1'b1);
        rmode = 1'b0;
        wait_idle();
        ahb_read(32'h8, rd);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL stall_fcnt got %0d required 4", rd); end
    endtask

    task automatic test_fcnt_clear();
        rdy_fix = 1'b0;
        send_beat(2, 16'hABCD, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'h8; hwrite_s = 1'b1;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = 32'h1234;
        rdy_fix = 1'b1;
        @(posedge clk); #1;
        wait_idle();
        ahb_read(32'h8, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL fcnt_clear_race got %0d required 0", rd); end
    endtask

    task automatic test_swdone_race();
        exp_t x;
        ahb_write(32'h0, 32'h105);
        send_beat(2, 16'h5555, 1'b1, 1'b1, 1'b1);
        wait_idle();
        hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'hC; hwrite_s = 1'b1;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = 32'h1;
        tdata_s[1*DW +: DW] = 16'h7777; tuser_s[1] = 1'b1; tlast_s[1] = 1'b0; tvalid_s[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (tready_s[1] !== 1'b1) begin errors++; $display("FAIL race_sof_ready got %b required 1", tready_s[1]); end
        @(posedge clk); #1;
        x.stamp = cyc; x.u = 1'b1; x.l = 1'b0; x.d = 16'h7777;
        q.push_back(x);
        tvalid_s[1] = 1'b0;
        ahb_read(32'hC, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL swdone_race got %h required 1", rd); end
        send_beat(1, 16'h7778, 1'b0, 1'b1, 1'b1);
        wait_idle();
        ahb_write(32'hC, 32'h1);
        ahb_read(32'hC, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL swdone_clear got %h required 0", rd); end
    endtask

    task automatic test_sel_invalid();
        ahb_write(32'h0, 32'h505);
        ahb_read(32'h0, rd);
        checks++;
        if (rd !== 32'h105) begin errors++; $display("FAIL sel_eq_ch got %h required 105", rd); end
        ahb_write(32'h0, 32'h707);
        ahb_read(32'h0, rd);
        checks++;
        if (rd !== 32'h107) begin errors++; $display("FAIL sel_gt_ch got %h required 107", rd); end
        ahb_write(32'h0, 32'h105);
    endtask

    task automatic test_reset_mid();
        ahb_read(32'h0, rd);
        for (int i = 0; i < 500; i++)
            send_beat(1, 16'(i), i == 0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if ({tvalid_m, tlast_m, tuser_m, tdata_m, tready_s, interrupt, hrdata_s} !== '0) begin
            errors++;
            $display("FAIL midreset_out tv=%b tl=%b tu=%b td=%h tr=%b irq=%b hr=%h required 0",
                     tvalid_m, tlast_m, tuser_m, tdata_m, tready_s, interrupt, hrdata_s);
        end
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ahb_read(32'h8, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_fcnt got %0d required 0", rd); end
        arm_first = 1'b1;
        ahb_write(32'h0, 32'h105);
        for (int i = 0; i < 3; i++)
            send_beat(1, 16'(501 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send_beat(1, 16'(16'hA0 + i), i == 0, i == 3, 1'b1);
        wait_idle();
        checks++;
        if (arm_first || first_user !== 1'b1) begin
            errors++; $display("FAIL first_after_reset tuser=%b armed=%b required tuser 1", first_user, arm_first);
        end
        ahb_read(32'h8, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL after_reset_fcnt got %0d required 1", rd); end
    endtask

    initial begin
        reset = 1'b1;
        tdata_s = '0; tvalid_s = '0; tlast_s = '0; tuser_s = '0;
        haddr_s = '0; hwdata_s = '0; hburst_s = '0; hsize_s = 3'd2; htrans_s = '0;
        hwrite_s = 1'b0; hsel_s = 1'b0;
        checks = 0; errors = 0; cyc = 0; frames_seen = 0;
        rmode = 1'b0; rdy_fix = 1'b1; rnd_bit = 1'b1; lat_chk = 1'b0;
        arm_first = 1'b0; first_user = 1'b0; stall_prev = 1'b0; stall_val = '0;
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk); #1;
                rnd_bit = 1'($urandom_range(0, 1));
            end
            forever begin
                @(negedge clk);
                if (reset) begin
                    stall_prev = 1'b0;
                end else begin
                    if (stall_prev && tvalid_m) begin
                        checks++;
                        if ({tuser_m, tlast_m, tdata_m} !== stall_val) begin
                            errors++;
                            $display("FAIL stall_hold got %h required %h", {tuser_m, tlast_m, tdata_m}, stall_val);
                        end
                    end
                    if (tvalid_m && tready_m) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_beat data=%h user=%b last=%b", tdata_m, tuser_m, tlast_m);
                        end else begin
                            e = q.pop_front();
                            if ({tuser_m, tlast_m, tdata_m} !== {e.u, e.l, e.d}) begin
                                errors++;
                                $display("FAIL beat got u=%b l=%b d=%h required u=%b l=%b d=%h",
                                         tuser_m, tlast_m, tdata_m, e.u, e.l, e.d);
                            end
                            if (lat_chk) begin
                                checks++;
                                if (e.stamp != cyc) begin
                                    errors++;
                                    $display("FAIL latency got %0d cycles required 1", cyc - e.stamp + 1);
                                end
                            end
                        end
                        if (tlast_m) frames_seen++;
                        if (arm_first) begin
                            first_user = tuser_m;
                            arm_first  = 1'b0;
                        end
                    end
                    stall_prev = tvalid_m && !tready_m;
                    stall_val  = {tuser_m, tlast_m, tdata_m};
                end
            end
        join_none

        test_reset();
        test_basic();
        test_drain();
        test_switch();
        test_stall();
        test_fcnt_clear();
        test_swdone_race();
        test_sel_invalid();
        test_reset_mid();

        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL leftover_beats got %0d required 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
